// File: rtl/line_window_buf.sv
// line_window_buf: three-bank circular line memory that pairs the two most
// recent complete lines with the live pixel stream. It emits a 3x3
// neighbourhood window for every written pixel once three lines and three
// columns of the current line are present.
//
// Ports:
//   clk       pixel clock
//   rst       asynchronous active-low reset
//   frame_en  new-frame pulse; flushes window state (highest priority)
//   wr_en     pixel strobe; pix_in is stored at the current column
//   shift_en  end-of-line pulse; rotates the line pointer if the line is non-empty
//   pix_in    input pixel
//   win       3x3 window, win[DW*(3*r+c) +: DW], r=0 oldest row, c=0 oldest column
//   win_valid win holds a complete window
//   line_cnt  completed lines this frame, saturating
//   state     0 EMPTY, 1 FILL1, 2 RUN
//   ovf       sticky: write attempted past the end of the line
//
// Build option: define LWB_OUT_REG_EN to add an output register stage on
// win/win_valid (latency N+2 instead of N+1).

module line_window_buf #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LINE_W = 640,
  parameter int unsigned CW     = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_en,
  input  logic            wr_en,
  input  logic            shift_en,
  input  logic [DW-1:0]   pix_in,
  output logic [9*DW-1:0] win,
  output logic            win_valid,
  output logic [CW-1:0]   line_cnt,
  output logic [1:0]      state,
  output logic            ovf
);

  localparam int unsigned AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  typedef enum logic [1:0] {StEmpty = 2'd0, StFill1 = 2'd1, StRun = 2'd2} state_e;

  state_e          state_q;
  logic [CW-1:0]   wr_col_q;
  logic [CW-1:0]   line_cnt_q;
  logic [1:0]      ptr_q;
  logic            ovf_q;
  logic [DW-1:0]   cr_q [3][3];  // column regs [row][col]
  logic [9*DW-1:0] win_q;
  logic            win_valid_q;

  // Line memories are not reset.
  logic [DW-1:0] mem0 [2**AW];
  logic [DW-1:0] mem1 [2**AW];
  logic [DW-1:0] mem2 [2**AW];

  logic            col_full;
  logic            wr_ok;
  logic            sh_ok;
  logic            valid_nxt;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   rd_old;
  logic [DW-1:0]   rd_mid;
  logic [DW-1:0]   col_nxt [3][3];
  logic [9*DW-1:0] win_nxt;

  assign col_full  = (wr_col_q == CW'(LINE_W));
  assign wr_ok     = wr_en && !frame_en && !col_full;
  assign sh_ok     = shift_en && !frame_en && (wr_col_q != '0);
  assign addr      = wr_col_q[AW-1:0];
  // Window is only complete once three columns of the current line exist.
  assign valid_nxt = wr_ok && (state_q == StRun) && (wr_col_q >= CW'(2));

  // Bank ptr_q holds the current line; ptr+2 holds line-1, ptr+1 line-2 (mod 3).
  always_comb begin
    rd_old = '0;
    rd_mid = '0;
    case (ptr_q)
      2'd0: begin rd_old = mem1[addr]; rd_mid = mem2[addr]; end
      2'd1: begin rd_old = mem2[addr]; rd_mid = mem0[addr]; end
      default: begin rd_old = mem0[addr]; rd_mid = mem1[addr]; end
    endcase
  end

  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        col_nxt[r][c] = cr_q[r][c+1];
      end
    end
    col_nxt[0][2] = rd_old;
    col_nxt[1][2] = rd_mid;
    col_nxt[2][2] = pix_in;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_nxt[DW*(3*r+c) +: DW] = col_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (ptr_q)
        2'd0:    mem0[addr] <= pix_in;
        2'd1:    mem1[addr] <= pix_in;
        default: mem2[addr] <= pix_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      wr_col_q    <= '0;
      line_cnt_q  <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          cr_q[r][c] <= '0;
        end
      end
    end else if (frame_en) begin
      // Line pointer and win are kept; everything else restarts.
      state_q     <= StEmpty;
      wr_col_q    <= '0;
      line_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      win_valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          cr_q[r][c] <= '0;
        end
      end
    end else begin
      win_valid_q <= valid_nxt;
      if (wr_ok) begin
        cr_q <= col_nxt;
      end
      if (valid_nxt) begin
        win_q <= win_nxt;
      end
      if (wr_en && col_full) begin
        ovf_q <= 1'b1;
      end
      if (sh_ok) begin
        ptr_q    <= (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        wr_col_q <= '0;
        if (line_cnt_q != '1) begin
          line_cnt_q <= line_cnt_q + CW'(1);
        end
        case (state_q)
          StEmpty: state_q <= StFill1;
          default: state_q <= StRun;
        endcase
      end else if (wr_ok) begin
        wr_col_q <= wr_col_q + CW'(1);
      end
    end
  end

`ifdef LWB_OUT_REG_EN
  logic [9*DW-1:0] win_o_q;
  logic            win_valid_o_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_o_q       <= '0;
      win_valid_o_q <= 1'b0;
    end else if (frame_en) begin
      win_valid_o_q <= 1'b0;
    end else begin
      win_o_q       <= win_q;
      win_valid_o_q <= win_valid_q;
    end
  end

  assign win       = win_o_q;
  assign win_valid = win_valid_o_q;
`else
  assign win       = win_q;
  assign win_valid = win_valid_q;
`endif

  assign line_cnt = line_cnt_q;
  assign state    = state_q;
  assign ovf      = ovf_q;

endmodule
